// File: rtl/multdiv_seq.sv
// multdiv_seq
//   Shares one iterative multiplier and one iterative divider between pipeline
//   requests. A request is accepted only while idle; its operands are latched
//   and held on unit_operandA/B for the whole operation because both units
//   sample their operands every cycle. The selected unit gets a one-cycle
//   start pulse, the sequencer waits for that unit's ready flag (or a
//   timeout), then returns the result, exception and destination tag with a
//   one-cycle valid strobe. busy stalls the pipeline while an op is in flight.
//
// Ports
//   clock, reset                      rising-edge clock, async active-high reset
//   start_mult, start_div             request strobes, sampled in IDLE only
//   req_operandA/B, req_tag           request operands and destination tag
//   unit_operandA/B                   latched operands to both units
//   ctrl_MULT, ctrl_DIV               one-cycle unit start pulses
//   mult_result/exception/resultRDY   multiplier return path
//   div_result/exception/resultRDY    divider return path
//   busy                              operation in flight
//   result, result_exception          captured result, held until next capture
//   result_valid, result_tag          completion strobe and tag
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_mult/start_div; operands latched on accept
// ISSUE | one cycle; start pulse driven to the selected unit
// WAIT  | counting cycles until the selected unit's RDY or timeout
// DONE  | one cycle; result_valid strobe with captured result and tag

module multdiv_seq #(
  parameter int TIMEOUT = 40,
  parameter int TAG_W   = 5
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start_mult,
  input  logic             start_div,
  input  logic [31:0]      req_operandA,
  input  logic [31:0]      req_operandB,
  input  logic [TAG_W-1:0] req_tag,
  output logic [31:0]      unit_operandA,
  output logic [31:0]      unit_operandB,
  output logic             ctrl_MULT,
  output logic             ctrl_DIV,
  input  logic [31:0]      mult_result,
  input  logic             mult_exception,
  input  logic             mult_resultRDY,
  input  logic [31:0]      div_result,
  input  logic             div_exception,
  input  logic             div_resultRDY,
  output logic             busy,
  output logic [31:0]      result,
  output logic             result_exception,
  output logic             result_valid,
  output logic [TAG_W-1:0] result_tag
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, DONE} state_t;

  localparam int              CNT_W    = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

  state_t           state;
  logic             op_div;
  logic [TAG_W-1:0] tag_q;
  logic [CNT_W-1:0] cnt;
  logic             sel_rdy;
  logic [31:0]      sel_result;
  logic             sel_exception;

  assign sel_rdy       = op_div ? div_resultRDY  : mult_resultRDY;
  assign sel_result    = op_div ? div_result     : mult_result;
  assign sel_exception = op_div ? div_exception  : mult_exception;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state            <= IDLE;
      op_div           <= 1'b0;
      tag_q            <= '0;
      cnt              <= '0;
      unit_operandA    <= '0;
      unit_operandB    <= '0;
      ctrl_MULT        <= 1'b0;
      ctrl_DIV         <= 1'b0;
      busy             <= 1'b0;
      result           <= '0;
      result_exception <= 1'b0;
      result_valid     <= 1'b0;
      result_tag       <= '0;
    end else begin
      ctrl_MULT    <= 1'b0;
      ctrl_DIV     <= 1'b0;
      result_valid <= 1'b0;
      case (state)
        IDLE: begin
          cnt <= '0;
          if (start_mult || start_div) begin
            unit_operandA <= req_operandA;
            unit_operandB <= req_operandB;
            tag_q         <= req_tag;
            op_div        <= !start_mult;   // multiply wins when both are raised
            busy          <= 1'b1;
            if (!start_mult && req_operandB == 32'd0) begin
              // divide by zero never reaches the divider
              state            <= DONE;
              result           <= '0;
              result_exception <= 1'b1;
              result_valid     <= 1'b1;
              result_tag       <= req_tag;
            end else begin
              state     <= ISSUE;
              ctrl_MULT <= start_mult;
              ctrl_DIV  <= !start_mult;
            end
          end
        end
        ISSUE: begin
          cnt   <= '0;
          state <= WAIT;
        end
        WAIT: begin
          cnt <= cnt + 1'b1;
          // RDY in the first WAIT cycle may be left over from an earlier op
          if (cnt != '0 && sel_rdy) begin
            state            <= DONE;
            result           <= sel_result;
            result_exception <= sel_exception;
            result_valid     <= 1'b1;
            result_tag       <= tag_q;
          end else if (cnt == CNT_LAST) begin
            state            <= DONE;
            result           <= '0;
            result_exception <= 1'b1;
            result_valid     <= 1'b1;
            result_tag       <= tag_q;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_multdiv_seq.sv
module tb_multdiv_seq;

  localparam int TAG_W = 5;

  logic             clock = 1'b0;
  logic             reset = 1'b1;
  logic             start_mult = 1'b0;
  logic             start_div = 1'b0;
  logic [31:0]      req_operandA = '0;
  logic [31:0]      req_operandB = '0;
  logic [TAG_W-1:0] req_tag = '0;
  logic [31:0]      unit_operandA, unit_operandB;
  logic             ctrl_MULT, ctrl_DIV;
  logic [31:0]      mult_result = '0;
  logic             mult_exception = 1'b0;
  logic             mult_resultRDY = 1'b0;
  logic [31:0]      div_result = '0;
  logic             div_exception = 1'b0;
  logic             div_resultRDY = 1'b0;
  logic             busy;
  logic [31:0]      result;
  logic             result_exception;
  logic             result_valid;
  logic [TAG_W-1:0] result_tag;

  int n_tests = 0;
  int n_fail  = 0;

  multdiv_seq #(.TIMEOUT(40), .TAG_W(TAG_W)) dut (
    .clock(clock), .reset(reset),
    .start_mult(start_mult), .start_div(start_div),
    .req_operandA(req_operandA), .req_operandB(req_operandB), .req_tag(req_tag),
    .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
    .ctrl_MULT(ctrl_MULT), .ctrl_DIV(ctrl_DIV),
    .mult_result(mult_result), .mult_exception(mult_exception),
    .mult_resultRDY(mult_resultRDY),
    .div_result(div_result), .div_exception(div_exception),
    .div_resultRDY(div_resultRDY),
    .busy(busy), .result(result), .result_exception(result_exception),
    .result_valid(result_valid), .result_tag(result_tag)
  );

  always #5 clock = ~clock;

  // unit models: results track the held operands; RDY after a fixed latency
  longint m_prod;
  int     d_quo;
  int     m_cnt = 0;
  int     d_cnt = 0;
  bit     div_dead = 1'b0;
  bit     mult_stale = 1'b0;

  assign m_prod = longint'($signed(unit_operandA)) * longint'($signed(unit_operandB));
  always_comb begin
    d_quo = 0;
    if (unit_operandB != 32'd0)
      d_quo = int'($signed(unit_operandA)) / int'($signed(unit_operandB));
  end

  always @(posedge clock) begin
    mult_result    <= m_prod[31:0];
    mult_exception <= (m_prod[63:31] != {33{m_prod[31]}});
    div_result     <= d_quo;
    div_exception  <= (unit_operandB == 32'd0);
    mult_resultRDY <= mult_stale;
    div_resultRDY  <= 1'b0;
    if (ctrl_MULT) m_cnt <= 4;
    else if (m_cnt > 0) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) mult_resultRDY <= 1'b1;
    end
    if (ctrl_DIV) d_cnt <= 33;
    else if (d_cnt > 0) begin
      d_cnt <= d_cnt - 1;
      if (d_cnt == 1) div_resultRDY <= !div_dead;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue one request and follow it to completion. lat = cycles from the
  // accepting edge to the cycle where result_valid is seen.
  task automatic run_op(input string nm, input logic sm, input logic sd,
                        input logic [31:0] a, input logic [31:0] b,
                        input logic [TAG_W-1:0] tg, input logic [31:0] er,
                        input logic ee, input int lat, input int nm_exp,
                        input int nd_exp);
    int cyc, n_m, n_d, first_ctrl;
    bit busy_drop, op_bad;
    n_m = 0; n_d = 0; first_ctrl = 0; busy_drop = 0; op_bad = 0;
    @(negedge clock);
    start_mult = sm; start_div = sd;
    req_operandA = a; req_operandB = b; req_tag = tg;
    @(negedge clock);
    start_mult = 1'b0; start_div = 1'b0;
    req_operandA = $urandom; req_operandB = $urandom; req_tag = ~tg;
    cyc = 1;
    while (!result_valid && cyc < 200) begin
      if (ctrl_MULT) n_m++;
      if (ctrl_DIV) n_d++;
      if ((ctrl_MULT || ctrl_DIV) && first_ctrl == 0) first_ctrl = cyc;
      if (!busy) busy_drop = 1'b1;
      if (unit_operandA != a || unit_operandB != b) op_bad = 1'b1;
      @(negedge clock);
      cyc++;
    end
    chk({nm, " valid"}, 32'(result_valid), 32'd1);
    chk({nm, " latency"}, cyc, lat);
    chk({nm, " result"}, result, er);
    chk({nm, " exception"}, 32'(result_exception), 32'(ee));
    chk({nm, " tag"}, 32'(result_tag), 32'(tg));
    chk({nm, " mult pulses"}, n_m, nm_exp);
    chk({nm, " div pulses"}, n_d, nd_exp);
    if (nm_exp + nd_exp > 0) chk({nm, " pulse cycle"}, first_ctrl, 1);
    chk({nm, " busy held"}, 32'({busy_drop, busy}), 32'b01);
    chk({nm, " operands held"}, 32'({op_bad, unit_operandB == b}), 32'b01);
    @(negedge clock);
    chk({nm, " busy after"}, 32'(busy), 32'd0);
    chk({nm, " valid after"}, 32'(result_valid), 32'd0);
    chk({nm, " result held"}, result, er);
    chk({nm, " tag held"}, 32'(result_tag), 32'(tg));
  endtask

  initial begin
    int n_v, n_b;
    #2;
    chk("reset busy/ctrl/valid", 32'({busy, ctrl_MULT, ctrl_DIV, result_valid}), 32'd0);
    chk("reset result", result, 32'd0);
    chk("reset exc/tag", 32'({result_exception, result_tag}), 32'd0);
    chk("reset operandA", unit_operandA, 32'd0);
    chk("reset operandB", unit_operandB, 32'd0);
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);

    run_op("div 100/7",  1'b0, 1'b1, 32'd100, 32'd7, 5'd3, 32'd14, 1'b0, 36, 0, 1);
    run_op("mul -6*5",   1'b1, 1'b0, 32'hFFFF_FFFA, 32'd5, 5'd9, 32'hFFFF_FFE2, 1'b0, 7, 1, 0);
    run_op("div 5/0",    1'b0, 1'b1, 32'd5, 32'd0, 5'd12, 32'd0, 1'b1, 1, 0, 0);
    run_op("both 3,4",   1'b1, 1'b1, 32'd3, 32'd4, 5'd17, 32'd12, 1'b0, 7, 1, 0);
    run_op("mul ovf",    1'b1, 1'b0, 32'h4000_0001, 32'd4, 5'd30, 32'd4, 1'b1, 7, 1, 0);

    mult_stale = 1'b1;
    run_op("mul stale rdy", 1'b1, 1'b0, 32'd7, 32'd8, 5'd5, 32'd56, 1'b0, 4, 1, 0);
    mult_stale = 1'b0;

    div_dead = 1'b1;
    run_op("div timeout", 1'b0, 1'b1, 32'd1000, 32'd3, 5'd20, 32'd0, 1'b1, 42, 0, 1);
    div_dead = 1'b0;

    // reset while waiting on the divider
    @(negedge clock);
    start_div = 1'b1; req_operandA = 32'd100; req_operandB = 32'd5; req_tag = 5'd7;
    @(negedge clock);
    start_div = 1'b0;
    repeat (10) @(negedge clock);
    chk("pre-reset busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async reset busy/ctrl/valid", 32'({busy, ctrl_MULT, ctrl_DIV, result_valid}), 32'd0);
    chk("async reset result", result, 32'd0);
    chk("async reset operandB", unit_operandB, 32'd0);
    @(negedge clock);
    reset = 1'b0;
    n_v = 0; n_b = 0;
    repeat (45) begin
      @(negedge clock);
      if (result_valid) n_v++;
      if (busy) n_b++;
    end
    chk("stale div rdy valid", n_v, 0);
    chk("stale div rdy busy", n_b, 0);
    chk("stale div rdy result", result, 32'd0);
    run_op("div 24/4", 1'b0, 1'b1, 32'd24, 32'd4, 5'd2, 32'd6, 1'b0, 36, 0, 1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/multdiv_seq.md
Name: multdiv_seq

Overview:
Sequencer that shares the iterative multiplier and divider between pipeline requests. It performs these functions:
- Accepts one mult or div request at a time.
- Latches the operands and holds them stable for the whole operation, because both units read their operands every cycle.
- Issues the one-cycle ctrl_MULT/ctrl_DIV start pulse and waits for the unit's ready flag.
- Captures the result and exception and returns them with the destination register tag.
- Asserts busy so the pipeline stalls while an operation is in flight.

Parameters:
TIMEOUT, 40, cycles in WAIT without a ready flag before a forced exception completion (must exceed the divider's 33-cycle latency)
TAG_W, 5, width of destination register tag

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
start_mult  in  1  request multiply (sampled in IDLE only)
start_div  in  1  request divide (sampled in IDLE only)
req_operandA  in  32  operand A of request
req_operandB  in  32  operand B of request
req_tag  in  TAG_W  destination register of request
unit_operandA  out  32  latched operand A to both units
unit_operandB  out  32  latched operand B to both units
ctrl_MULT  out  1  one-cycle multiplier start pulse
ctrl_DIV  out  1  one-cycle divider start pulse
mult_result  in  32  multiplier result
mult_exception  in  1  multiplier overflow
mult_resultRDY  in  1  multiplier ready
div_result  in  32  divider result
div_exception  in  1  divider divide-by-zero
div_resultRDY  in  1  divider ready
busy  out  1  operation in flight; pipeline stall
result  out  32  captured result, held until next capture
result_exception  out  1  captured exception, held with result
result_valid  out  1  one-cycle completion strobe
result_tag  out  TAG_W  tag of completed operation

Behaviour:
- Reset (async, any state):
  - State goes to IDLE.
  - All outputs are 0: busy, ctrl_*, result, result_exception, result_valid, result_tag, unit_operand*.
  - Cycle counter cleared.
  - Mid-operation reset abandons the op. Unit ready flags are ignored until the next ISSUE.
- State register: IDLE, ISSUE, WAIT, DONE. busy = (state != IDLE).
- IDLE:
  - Sample requests on start_mult|start_div.
  - Latch req_operandA/B into unit_operand*, latch req_tag, record op type, then go to ISSUE.
  - Both starts high: mult wins, div dropped.
  - DIV with req_operandB==0 short-circuits and never starts the divider:
    - Go directly to DONE with result=0 and result_exception=1.
    - ctrl_DIV stays low.
- ISSUE (exactly 1 cycle):
  - ctrl_MULT or ctrl_DIV = 1 per op type; the other stays 0.
  - Clear counter, go to WAIT.
- WAIT:
  - Counter increments each cycle.
  - Only the selected unit's RDY is observed, and only from the second WAIT cycle on. This ignores a stale RDY left from a previous op or counter wrap.
  - On RDY: capture the selected unit's result and exception, then go to DONE.
  - If the counter reaches TIMEOUT with no RDY: result=0, result_exception=1, go to DONE.
  - RDY and timeout in the same cycle: RDY wins.
- DONE (exactly 1 cycle):
  - result_valid=1, result_tag valid.
  - Go to IDLE.
  - A start presented during DONE is ignored; the next request is accepted the cycle after.
- Starts while busy are ignored; the pipeline is stalled by busy.
- unit_operand* change only on IDLE acceptance and stay constant through ISSUE/WAIT/DONE.
- Latency:
  - Accept edge to result_valid = 2 + N cycles, where N = WAIT cycles to RDY (divider: N≈33).
  - Short-circuit divide by zero: result_valid 1 cycle after acceptance.
- result, result_exception and result_tag hold their values after DONE until the next capture.

Test Plan:
- Divide 100 / 7, tag 3:
  - Response: ctrl_DIV pulses exactly once, 1 cycle after accept.
  - Response: busy high throughout.
  - Response: result_valid after RDY with result=14, exception=0, tag=3.
  - Response: unit_operandB stable at 7 for the whole op.
- Multiply -6 × 5, tag 9: result=-30 (0xFFFFFFE2), exception=0, tag=9, ctrl_DIV never asserted.
- Divide 5 / 0: no ctrl_DIV; result_valid 1 cycle after accept with result=0, exception=1.
- start_mult and start_div together (A=3, B=4): multiply executes, result=12, only ctrl_MULT pulses.
- Divider model never raises RDY: forced completion after TIMEOUT=40 WAIT cycles with exception=1, result=0; busy drops the next cycle.
- Reset asserted mid-WAIT:
  - Response: busy, ctrl_* and result_valid drop to 0 immediately (async).
  - Response: a later divider RDY is ignored.
  - Response: a new request 24/4 then returns 6.
